branch_sequencer: RTL and testbench

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

---
 rtl/branch_sequencer.sv | 162 ++++++++++++++++
 tb/tb_branch_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer.sv
// -----------------------------------------------------------------------------
// branch_sequencer
//   Three-state sequencer for conditional branches. A request is latched in
//   IDLE. The latched operands drive an external comparator. Its verdict is
//   sampled in EVAL and folded into a registered response (taken / next-PC /
//   trap / cause). The response is held in RESP until the consumer takes it.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_pc, req_imm          branch PC and sign-extended offset
//   req_funct3, req_rs1/rs2  comparison selector and operands
//   cmp_funct3, cmp_a/b      to comparator (always from latched registers)
//   cmp_result, cmp_error    from comparator (combinational)
//   resp_valid / resp_ready  response handshake
//   resp_taken, resp_next_pc, resp_trap, resp_cause
//   taken_count              saturating count of taken, non-trapping branches
// -----------------------------------------------------------------------------
module branch_sequencer #(
   parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_pc,
   input  logic [31:0] req_imm,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_rs1,
   input  logic [31:0] req_rs2,
   output logic [2:0]  cmp_funct3,
   output logic [31:0] cmp_a,
   output logic [31:0] cmp_b,
   input  logic        cmp_result,
   input  logic        cmp_error,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_taken,
   output logic [31:0] resp_next_pc,
   output logic        resp_trap,
   output logic [1:0]  resp_cause,
   output logic [31:0] taken_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_MISALGN = 2'd2;

   state_t      r_state;
   state_t      w_next;

   logic [31:0] r_pc;
   logic [31:0] r_imm;
   logic [2:0]  r_funct3;
   logic [31:0] r_rs1;
   logic [31:0] r_rs2;

   logic        r_resp_taken;
   logic [31:0] r_resp_next_pc;
   logic        r_resp_trap;
   logic [1:0]  r_resp_cause;
   logic [31:0] r_taken_count;

   logic [31:0] w_target;
   logic [31:0] w_fall;
   logic        w_taken;
   logic        w_trap;
   logic [1:0]  w_cause;
   logic [31:0] w_next_pc;
   logic        w_accept;

   // Handshake outputs are gated by rst so nothing is offered during reset.
   assign req_ready  = (r_state == IDLE) && !rst;
   assign resp_valid = (r_state == RESP) && !rst;
   assign w_accept   = req_valid && req_ready;

   assign cmp_funct3 = r_funct3;
   assign cmp_a      = r_rs1;
   assign cmp_b      = r_rs2;

   assign resp_taken   = r_resp_taken;
   assign resp_next_pc = r_resp_next_pc;
   assign resp_trap    = r_resp_trap;
   assign resp_cause   = r_resp_cause;
   assign taken_count  = r_taken_count;

   // Both additions wrap naturally at 32 bits.
   assign w_target = r_pc + r_imm;
   assign w_fall   = r_pc + 32'd4;

   // Response resolution. A comparator error beats everything. Target
   // alignment only matters when the branch would actually be taken.
   always_comb begin
      w_taken   = 1'b0;
      w_trap    = 1'b0;
      w_cause   = CAUSE_NONE;
      w_next_pc = w_fall;
      if (cmp_error) begin
         w_trap    = 1'b1;
         w_cause   = CAUSE_ILLEGAL;
         w_next_pc = TRAP_VECTOR;
      end else if (cmp_result && (w_target[1:0] != 2'b00)) begin
         w_trap    = 1'b1;
         w_cause   = CAUSE_MISALGN;
         w_next_pc = TRAP_VECTOR;
      end else if (cmp_result) begin
         w_taken   = 1'b1;
         w_next_pc = w_target;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = EVAL;
         EVAL:    w_next = RESP;
         RESP:    if (resp_valid && resp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= IDLE;
         r_pc           <= '0;
         r_imm          <= '0;
         r_funct3       <= '0;
         r_rs1          <= '0;
         r_rs2          <= '0;
         r_resp_taken   <= 1'b0;
         r_resp_next_pc <= '0;
         r_resp_trap    <= 1'b0;
         r_resp_cause   <= CAUSE_NONE;
         r_taken_count  <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_pc     <= req_pc;
            r_imm    <= req_imm;
            r_funct3 <= req_funct3;
            r_rs1    <= req_rs1;
            r_rs2    <= req_rs2;
         end
         if (r_state == EVAL) begin
            r_resp_taken   <= w_taken;
            r_resp_next_pc <= w_next_pc;
            r_resp_trap    <= w_trap;
            r_resp_cause   <= w_cause;
            // w_taken already excludes traps; hold at all-ones.
            if (w_taken && (r_taken_count != 32'hFFFF_FFFF))
               r_taken_count <= r_taken_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_branch_sequencer.sv
module tb_branch_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_pc;
   logic [31:0] req_imm;
   logic [2:0]  req_funct3;
   logic [31:0] req_rs1;
   logic [31:0] req_rs2;
   logic [2:0]  cmp_funct3;
   logic [31:0] cmp_a;
   logic [31:0] cmp_b;
   logic        cmp_result;
   logic        cmp_error;
   logic        resp_valid;
   logic        resp_ready;
   logic        resp_taken;
   logic [31:0] resp_next_pc;
   logic        resp_trap;
   logic [1:0]  resp_cause;
   logic [31:0] taken_count;

   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

   branch_sequencer dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_pc(req_pc), .req_imm(req_imm), .req_funct3(req_funct3),
      .req_rs1(req_rs1), .req_rs2(req_rs2),
      .cmp_funct3(cmp_funct3), .cmp_a(cmp_a), .cmp_b(cmp_b),
      .cmp_result(cmp_result), .cmp_error(cmp_error),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_taken(resp_taken), .resp_next_pc(resp_next_pc),
      .resp_trap(resp_trap), .resp_cause(resp_cause),
      .taken_count(taken_count)
   );

   // Reference RISC-V branch comparator (external environment).
   always_comb begin
      cmp_result = 1'b0;
      cmp_error  = 1'b0;
      case (cmp_funct3)
         3'd0: cmp_result = (cmp_a == cmp_b);
         3'd1: cmp_result = (cmp_a != cmp_b);
         3'd4: cmp_result = ($signed(cmp_a) <  $signed(cmp_b));
         3'd5: cmp_result = ($signed(cmp_a) >= $signed(cmp_b));
         3'd6: cmp_result = (cmp_a <  cmp_b);
         3'd7: cmp_result = (cmp_a >= cmp_b);
         default: cmp_error = 1'b1;
      endcase
   end

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [2:0]  f3;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic        taken;
      logic [31:0] npc;
      logic        trap;
      logic [1:0]  cause;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input vec_t v);
      req_valid  = 1'b1;
      req_pc     = v.pc;
      req_imm    = v.imm;
      req_funct3 = v.f3;
      req_rs1    = v.rs1;
      req_rs2    = v.rs2;
   endtask

   task automatic chk_resp(input vec_t v);
      chk({v.name, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({v.name, " taken"},      {31'd0, resp_taken}, {31'd0, v.taken});
      chk({v.name, " next_pc"},    resp_next_pc,        v.npc);
      chk({v.name, " trap"},       {31'd0, resp_trap},  {31'd0, v.trap});
      chk({v.name, " cause"},      {30'd0, resp_cause}, {30'd0, v.cause});
      chk({v.name, " count"},      taken_count,         v.cnt);
   endtask

   // Full transaction from an IDLE cycle with resp_ready high in RESP.
   task automatic run_txn(input vec_t v);
      drive_req(v);
      chk({v.name, " req_ready"}, {31'd0, req_ready}, 32'd1);
      tick();                                   // accepted -> EVAL
      req_valid = 1'b0;
      chk({v.name, " eval no resp"}, {31'd0, resp_valid}, 32'd0);
      chk({v.name, " eval busy"},    {31'd0, req_ready},  32'd0);
      tick();                                   // -> RESP
      chk_resp(v);
      resp_ready = 1'b1;
      tick();                                   // handshake -> IDLE
      resp_ready = 1'b0;
      chk({v.name, " post resp_valid"}, {31'd0, resp_valid}, 32'd0);
   endtask

   vec_t va, vb, vs;

   initial begin
      //            name        pc            imm           f3    rs1           rs2     tk npc           tr cause cnt
      vecs[0] = '{"beq_tk",   32'h1000,     32'h20,       3'd0, 32'd5,        32'd5,  1, 32'h1020,     0, 2'd0, 32'd1};
      vecs[1] = '{"bne_wrap", 32'hFFFF_FFFC, 32'h8,       3'd1, 32'd7,        32'd7,  0, 32'h0,        0, 2'd0, 32'd1};
      vecs[2] = '{"illegal2", 32'h2000,     32'h10,       3'd2, 32'd1,        32'd1,  0, 32'h100,      1, 2'd1, 32'd1};
      vecs[3] = '{"bltu_mis", 32'h1000,     32'h6,        3'd6, 32'd1,        32'd2,  0, 32'h100,      1, 2'd2, 32'd1};
      vecs[4] = '{"blt_neg",  32'h2000,     32'hFFFF_FFF0, 3'd4, 32'hFFFF_FFFF, 32'd1, 1, 32'h1FF0,     0, 2'd0, 32'd2};
      vecs[5] = '{"bgeu_tk",  32'h100,      32'h40,       3'd7, 32'hFFFF_FFFF, 32'd1, 1, 32'h140,      0, 2'd0, 32'd3};
      vecs[6] = '{"nt_misal", 32'h3000,     32'h3,        3'd0, 32'd1,        32'd2,  0, 32'h3004,     0, 2'd0, 32'd3};
      vecs[7] = '{"bge_tk",   32'h400,      32'h1000,     3'd5, 32'd5,        32'd3,  1, 32'h1400,     0, 2'd0, 32'd4};
      vecs[8] = '{"illegal3", 32'h500,      32'h8,        3'd3, 32'd9,        32'd9,  0, 32'h100,      1, 2'd1, 32'd4};
      vecs[9] = '{"tgt_wrap", 32'hFFFF_FFF0, 32'h20,      3'd0, 32'd0,        32'd0,  1, 32'h10,       0, 2'd0, 32'd5};

      rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
      req_pc = '0; req_imm = '0; req_funct3 = '0; req_rs1 = '0; req_rs2 = '0;
      tick(); tick();
      req_valid = 1'b1;                          // must not be taken during reset
      chk("rst req_ready",  {31'd0, req_ready},  32'd0);
      chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst count",      taken_count,         32'd0);
      chk("rst cmp_a",      cmp_a,               32'd0);
      chk("rst next_pc",    resp_next_pc,        32'd0);
      tick();
      req_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("post-rst req_ready", {31'd0, req_ready}, 32'd1);

      for (int i = 0; i < 10; i++) run_txn(vecs[i]);

      // Backpressure, req_valid held high throughout; the second request's
      // fields appear during EVAL/RESP and must be ignored until IDLE.
      va = '{"bp_a", 32'h500, 32'h8,  3'd0, 32'd4, 32'd4, 1, 32'h508, 0, 2'd0, 32'd6};
      vb = '{"bp_b", 32'h600, 32'h10, 3'd1, 32'd1, 32'd2, 1, 32'h610, 0, 2'd0, 32'd7};
      drive_req(va);
      tick();                                   // A accepted -> EVAL
      drive_req(vb);
      tick();                                   // -> RESP
      for (int c = 0; c < 5; c++) begin
         chk_resp(va);
         chk("bp req_ready", {31'd0, req_ready}, 32'd0);
         tick();
      end
      chk_resp(va);
      resp_ready = 1'b1;
      tick();                                   // single handshake -> IDLE
      resp_ready = 1'b0;
      chk("bp idle resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("bp idle req_ready",  {31'd0, req_ready},  32'd1);
      tick();                                   // B accepted -> EVAL
      req_valid = 1'b0;
      chk("bp b eval req_ready", {31'd0, req_ready},  32'd0);
      chk("bp b eval resp",      {31'd0, resp_valid}, 32'd0);
      tick();
      chk_resp(vb);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;

      // Reset while in EVAL: the in-flight taken branch is discarded.
      drive_req(vecs[0]);
      tick();                                   // -> EVAL
      req_valid = 1'b0;
      rst = 1'b1;
      tick();
      chk("rst-eval resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst-eval count",      taken_count,         32'd0);
      rst = 1'b0;
      tick();
      chk("rst-eval after resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst-eval after count",      taken_count,         32'd0);

      // Saturation: preload the counter, then one taken branch.
      force dut.r_taken_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_taken_count;
      #1;
      chk("sat preload", taken_count, 32'hFFFF_FFFF);
      vs = '{"sat", 32'h1000, 32'h20, 3'd0, 32'd5, 32'd5, 1, 32'h1020, 0, 2'd0, 32'hFFFF_FFFF};
      tick();
      run_txn(vs);
      chk("sat hold", taken_count, 32'hFFFF_FFFF);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
